serial_shifter: RTL
===================

# serial_shifter

Multi-cycle shifter executing the shift operations that the ALU shift decoder selects (SRL, LSHIFT2, LSHIFT10), driven by its `shift_right`/`sa` outputs. It sits in the ARC datapath directly downstream of the shift decoder, between bus B and the ALU result mux. It replaces a full barrel shifter with an iterative register shifter and a start/done handshake, so the control unit stalls while the shift completes.

## Interface

Parameters:
- `WIDTH`, 32: data width in bits.
- `SA_W`, 5: width of the shift-amount field. Must satisfy 2^SA_W = WIDTH.

Ports:
- `clk`  in  1  single system clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request a shift; sampled only in IDLE.
- `shift_right`  in  1  1 = logical right shift (zero fill), 0 = left shift (zero fill).
- `sa`  in  SA_W  shift amount, 0..WIDTH-1.
- `din`  in  WIDTH  operand to shift.
- `dout`  out  WIDTH  shift result; holds last result until the next accepted start.
- `busy`  out  1  high in SHIFT and DONE; start ignored while high.
- `done`  out  1  one-cycle pulse; `dout` is valid in that cycle and afterwards.

## Operation

- States: IDLE, SHIFT, DONE.
- IDLE: on `start`=1, latch `din` into the data register, `sa` into the down-counter `cnt`, and `shift_right` into the direction flag. Go to DONE if `sa`=0, else to SHIFT.
- SHIFT: each cycle, shift the data register by one bit in the latched direction and decrement `cnt`. When the step brings `cnt` to 0, go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE. `start` is not sampled in DONE.
- `dout` is the data register output. It changes only during SHIFT and at load, so intermediate values are visible while `busy`=1. Consumers sample `dout` only on `done` or later.
- Input changes after the start cycle have no effect. All operands are latched.
- Right shift is logical only: vacated MSBs are filled with 0. Vacated LSBs on a left shift are filled with 0.
- `sa` wider than WIDTH-1 cannot be encoded. No modulo logic is needed.

## Timing

- Reset (`rst_n`=0 at a rising edge): state=IDLE, `dout`=0, `cnt`=0, `busy`=0, `done`=0. This takes priority over every other event, including mid-SHIFT and in DONE. A reset in the same cycle as `start` discards the start.
- Label the cycle in which `start` is sampled in IDLE as cycle 0.
  - `busy`=1 from cycle 1 through the DONE cycle.
  - `done`=1 in cycle `sa`+1.
  - `busy`=0 and IDLE again in cycle `sa`+2.
- `sa`=0: `done` in cycle 1, with `dout`=`din`.
- Back-to-back: the earliest next accepted `start` is in cycle `sa`+2. Worst-case occupancy is WIDTH+1 cycles.
- `start` held high continuously: a new operation is accepted in every IDLE cycle. There is no edge detection.

## Configuration

- `SERIAL_SHIFTER_FAST4_EN` defined:
  - In SHIFT, if `cnt`>=4, shift by 4 and decrement by 4; otherwise shift by 1 and decrement by 1.
  - `done` occurs in cycle floor(`sa`/4) + (`sa` mod 4) + 1.
  - Results are identical to the non-FAST4 build.
- Not defined: one bit per cycle, latency `sa`+1 as above.

## Test plan

- Reset check: hold `rst_n`=0 for 2 cycles -> `dout`=0x00000000, `busy`=0, `done`=0.
- sa=0: `din`=0xDEADBEEF, `shift_right`=0, `sa`=0 -> `done` in cycle 1, `dout`=0xDEADBEEF.
- SRL full range: `din`=0x80000000, `shift_right`=1, `sa`=31 -> `done` in cycle 32 (FAST4: cycle 11), `dout`=0x00000001.
- LSHIFT2 / LSHIFT10:
  - `din`=0x00000001, `sa`=2, left -> `dout`=0x00000004, `done` in cycle 3.
  - `din`=0x003FFFFF, `sa`=10, left -> `dout`=0xFFFFFC00, `done` in cycle 11 (FAST4: cycle 5).
- Start while busy: launch `sa`=5 with `din`=0x00000020, right. Pulse `start` with `din`=0xFFFFFFFF in cycles 2 and 6 -> both ignored; `done` in cycle 6 with `dout`=0x00000001; IDLE in cycle 7.
- Reset mid-operation: launch `sa`=20, assert `rst_n`=0 in cycle 8 -> cycle 9 shows IDLE with `dout`=0, `busy`=0, and no `done` pulse. A following `start` with `sa`=1 and `din`=0x2, right -> `dout`=0x1.

Source files
------------

// File: rtl/serial_shifter.sv
// Iterative logical shifter with a start/done handshake, replacing a full barrel shifter.
// Define SERIAL_SHIFTER_FAST4_EN to shift by four bits per cycle while at least four steps remain.
module serial_shifter #(
   parameter int WIDTH = 32,
   parameter int SA_W  = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             shift_right,
   input  logic [SA_W-1:0]  sa,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] shifted;
   logic [SA_W-1:0]  cnt;
   logic [SA_W-1:0]  step;
   logic             dir_right;
   logic             load;

   always_comb begin
`ifdef SERIAL_SHIFTER_FAST4_EN
      step = (cnt >= SA_W'(4)) ? SA_W'(4) : SA_W'(1);
`else
      step = SA_W'(1);
`endif
      shifted = dir_right ? (data_q >> step) : (data_q << step);
   end

   always_comb begin
      next_state = state;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               next_state = (sa == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            if (cnt == step)
               next_state = DONE;
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Operands are captured once at load, so later input changes cannot disturb a shift in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         data_q    <= '0;
         cnt       <= '0;
         dir_right <= 1'b0;
      end else begin
         state <= next_state;
         if (load) begin
            data_q    <= din;
            cnt       <= sa;
            dir_right <= shift_right;
         end else if (state == SHIFT) begin
            data_q <= shifted;
            cnt    <= cnt - step;
         end
      end
   end

   assign dout = data_q;
   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule
